// File: rtl/bp_be_late_wb_queue_if.sv
// Late-writeback queue bus: memory-pipe enqueue, allocation scoreboard updates,
// and regfile write requests with their grants, plus the occupancy/pending status.
interface bp_be_late_wb_queue_if #(
    parameter int els_p            = 4,
    parameter int reg_addr_width_p = 5,
    parameter int data_width_p     = 64
);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int regs_lp  = 2 ** reg_addr_width_p;

    logic                        late_v_i;
    logic                        late_float_i;
    logic [reg_addr_width_p-1:0] late_rd_addr_i;
    logic [data_width_p-1:0]     late_data_i;
    logic                        late_yumi_o;

    logic                        alloc_v_i;
    logic                        alloc_float_i;
    logic [reg_addr_width_p-1:0] alloc_rd_addr_i;

    logic                        irf_w_v_o;
    logic                        frf_w_v_o;
    logic [reg_addr_width_p-1:0] rf_w_addr_o;
    logic [data_width_p-1:0]     rf_w_data_o;
    logic                        irf_w_yumi_i;
    logic                        frf_w_yumi_i;

    logic [regs_lp-1:0]          irf_pending_o;
    logic [regs_lp-1:0]          frf_pending_o;
    logic [cnt_w_lp-1:0]         count_o;
    logic                        empty_o;

    modport slave (
        input  late_v_i, late_float_i, late_rd_addr_i, late_data_i,
        input  alloc_v_i, alloc_float_i, alloc_rd_addr_i,
        input  irf_w_yumi_i, frf_w_yumi_i,
        output late_yumi_o, irf_w_v_o, frf_w_v_o, rf_w_addr_o, rf_w_data_o,
        output irf_pending_o, frf_pending_o, count_o, empty_o
    );

    modport master (
        output late_v_i, late_float_i, late_rd_addr_i, late_data_i,
        output alloc_v_i, alloc_float_i, alloc_rd_addr_i,
        output irf_w_yumi_i, frf_w_yumi_i,
        input  late_yumi_o, irf_w_v_o, frf_w_v_o, rf_w_addr_o, rf_w_data_o,
        input  irf_pending_o, frf_pending_o, count_o, empty_o
    );
endinterface

// File: rtl/bp_be_late_wb_queue.sv
// Late load writeback FIFO draining into the int/FP regfiles in strict order,
// with per-register pending scoreboards for issue-stage hazard stalls.
module bp_be_late_wb_queue_chk #(
    parameter int els_p        = 4,
    parameter int data_width_p = 64
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    input logic                          irf_w_v_i,
    input logic                          frf_w_v_i,
    input logic                          irf_w_yumi_i,
    input logic                          frf_w_yumi_i,
    input logic [$clog2(els_p+1)-1:0]    count_i,
    input logic                          empty_i,
    input logic [data_width_p-1:0]       head_data_i,
    input logic                          head_par_i
);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] els_cnt_lp = cnt_w_lp'(els_p);

    a_irf_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(irf_w_yumi_i && !irf_w_v_i));
    a_frf_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(frf_w_yumi_i && !frf_w_v_i));
    a_one_file_only: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(irf_w_v_i && frf_w_v_i));
    a_empty_matches_count: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        empty_i == (count_i == {cnt_w_lp{1'b0}}));
    a_count_bounded: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_i <= els_cnt_lp);
    a_head_parity: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !empty_i |-> (head_par_i == ^head_data_i));
endmodule

module bp_be_late_wb_queue #(
    parameter int els_p            = 4,
    parameter int reg_addr_width_p = 5,
    parameter int data_width_p     = 64
) (
    input logic                  clk_i,
    input logic                  reset_n_i,
    bp_be_late_wb_queue_if.slave wb
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int regs_lp  = 2 ** reg_addr_width_p;
    localparam logic [cnt_w_lp-1:0] els_cnt_lp = cnt_w_lp'(els_p);

    typedef struct packed {
        logic                        fp;
        logic [reg_addr_width_p-1:0] rd;
        logic [data_width_p-1:0]     data;
        logic                        par;
    } entry_t;

    function automatic logic calc_parity(input logic [data_width_p-1:0] d);
        return ^d;
    endfunction

    entry_t                mem_q [els_p];
    entry_t                mem_d [els_p];
    logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
    logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic [regs_lp-1:0]    irf_pend_q, irf_pend_d;
    logic [regs_lp-1:0]    frf_pend_q, frf_pend_d;

    logic                  late_yumi_s;
    logic                  store_s;
    entry_t                head_s;
    logic                  head_int_v_s;
    logic                  head_fp_v_s;
    logic                  retire_s;
    logic [regs_lp-1:0]    irf_set_s, irf_clr_s;
    logic [regs_lp-1:0]    frf_set_s, frf_clr_s;

    // Acceptance looks at occupancy only; a same-cycle retire never frees a slot.
    always_comb begin
        late_yumi_s = wb.late_v_i & (count_q < els_cnt_lp);
        store_s     = late_yumi_s
                    & (wb.late_float_i | (wb.late_rd_addr_i != {reg_addr_width_p{1'b0}}));
    end

    // Head request decode and retire detection.
    always_comb begin
        head_s       = mem_q[rptr_q];
        head_int_v_s = ~empty_q & ~head_s.fp;
        head_fp_v_s  = ~empty_q &  head_s.fp;
        retire_s     = (head_int_v_s & wb.irf_w_yumi_i) | (head_fp_v_s & wb.frf_w_yumi_i);
    end

    // Entry storage and pointer advance; pointers wrap naturally since els_p is a power of 2.
    always_comb begin
        mem_d = mem_q;
        if (store_s) begin
            mem_d[wptr_q] = '{fp:   wb.late_float_i,
                              rd:   wb.late_rd_addr_i,
                              data: wb.late_data_i,
                              par:  calc_parity(wb.late_data_i)};
            wptr_d = wptr_q + ptr_w_lp'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end
        if (retire_s) begin
            rptr_d = rptr_q + ptr_w_lp'(1'b1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Occupancy tracking, held separately from the pointers.
    always_comb begin
        count_d = count_q;
        case ({store_s, retire_s})
            2'b10:   count_d = count_q + cnt_w_lp'(1'b1);
            2'b01:   count_d = count_q - cnt_w_lp'(1'b1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == {cnt_w_lp{1'b0}});
    end

    // Scoreboards: retire clears, alloc sets, and set is applied last so a newer load wins.
    always_comb begin
        irf_clr_s = (retire_s & ~head_s.fp) ? (regs_lp'(1'b1) << head_s.rd) : {regs_lp{1'b0}};
        frf_clr_s = (retire_s &  head_s.fp) ? (regs_lp'(1'b1) << head_s.rd) : {regs_lp{1'b0}};
        irf_set_s = (wb.alloc_v_i & ~wb.alloc_float_i
                     & (wb.alloc_rd_addr_i != {reg_addr_width_p{1'b0}}))
                  ? (regs_lp'(1'b1) << wb.alloc_rd_addr_i) : {regs_lp{1'b0}};
        frf_set_s = (wb.alloc_v_i & wb.alloc_float_i)
                  ? (regs_lp'(1'b1) << wb.alloc_rd_addr_i) : {regs_lp{1'b0}};
        irf_pend_d = (irf_pend_q & ~irf_clr_s) | irf_set_s;
        frf_pend_d = (frf_pend_q & ~frf_clr_s) | frf_set_s;
    end

    // State registers; reset discards any queued entry and clears both scoreboards.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= {$bits(entry_t){1'b0}};
            end
            wptr_q     <= {ptr_w_lp{1'b0}};
            rptr_q     <= {ptr_w_lp{1'b0}};
            count_q    <= {cnt_w_lp{1'b0}};
            empty_q    <= 1'b1;
            irf_pend_q <= {regs_lp{1'b0}};
            frf_pend_q <= {regs_lp{1'b0}};
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            irf_pend_q <= irf_pend_d;
            frf_pend_q <= frf_pend_d;
        end
    end

    assign wb.late_yumi_o   = late_yumi_s;
    assign wb.irf_w_v_o     = head_int_v_s;
    assign wb.frf_w_v_o     = head_fp_v_s;
    assign wb.rf_w_addr_o   = head_s.rd;
    assign wb.rf_w_data_o   = head_s.data;
    assign wb.irf_pending_o = irf_pend_q;
    assign wb.frf_pending_o = frf_pend_q;
    assign wb.count_o       = count_q;
    assign wb.empty_o       = empty_q;

    bp_be_late_wb_queue_chk #(
        .els_p        (els_p),
        .data_width_p (data_width_p)
    ) u_chk (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .irf_w_v_i    (head_int_v_s),
        .frf_w_v_i    (head_fp_v_s),
        .irf_w_yumi_i (wb.irf_w_yumi_i),
        .frf_w_yumi_i (wb.frf_w_yumi_i),
        .count_i      (count_q),
        .empty_i      (empty_q),
        .head_data_i  (head_s.data),
        .head_par_i   (head_s.par)
    );
endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Directed bench for bp_be_late_wb_queue: a queue-based model checked every negedge,
// plus literal expectations at the key points of each scenario.
module tb_bp_be_late_wb_queue;
    localparam int ELS = 4;

    typedef struct packed {
        logic        f;
        logic [4:0]  rd;
        logic [63:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int          n_vec = 0;
    int          n_err = 0;
    ent_t        mq[$];
    logic [31:0] m_ipend = 32'h0;
    logic [31:0] m_fpend = 32'h0;

    bp_be_late_wb_queue_if wb ();

    bp_be_late_wb_queue dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .wb        (wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ipend = 32'h0;
        m_fpend = 32'h0;
    endtask

    // One clock of the reference behaviour: FIFO pop on matching grant, push if space.
    task automatic model_step();
        bit   acc;
        bit   ret;
        ent_t e;
        acc = wb.late_v_i && (mq.size() < ELS);
        ret = 1'b0;
        if (mq.size() > 0) begin
            if (!mq[0].f && wb.irf_w_yumi_i) ret = 1'b1;
            if (mq[0].f && wb.frf_w_yumi_i) ret = 1'b1;
        end
        if (ret) begin
            e = mq.pop_front();
            if (e.f) m_fpend[e.rd] = 1'b0;
            else     m_ipend[e.rd] = 1'b0;
        end
        if (wb.alloc_v_i) begin
            if (wb.alloc_float_i) m_fpend[wb.alloc_rd_addr_i] = 1'b1;
            else if (wb.alloc_rd_addr_i != 5'd0) m_ipend[wb.alloc_rd_addr_i] = 1'b1;
        end
        if (acc && (wb.late_float_i || wb.late_rd_addr_i != 5'd0)) begin
            e.f  = wb.late_float_i;
            e.rd = wb.late_rd_addr_i;
            e.d  = wb.late_data_i;
            mq.push_back(e);
        end
    endtask

    task automatic compare_outputs();
        check("count", 64'(wb.count_o), 64'(mq.size()));
        check("empty", 64'(wb.empty_o), 64'(mq.size() == 0));
        check("late_yumi", 64'(wb.late_yumi_o), 64'(wb.late_v_i && (mq.size() < ELS)));
        check("irf_pend", 64'(wb.irf_pending_o), 64'(m_ipend));
        check("frf_pend", 64'(wb.frf_pending_o), 64'(m_fpend));
        if (mq.size() > 0) begin
            check("irf_v", 64'(wb.irf_w_v_o), 64'(!mq[0].f));
            check("frf_v", 64'(wb.frf_w_v_o), 64'(mq[0].f));
            check("head_addr", 64'(wb.rf_w_addr_o), 64'(mq[0].rd));
            check("head_data", wb.rf_w_data_o, mq[0].d);
        end else begin
            check("irf_v_empty", 64'(wb.irf_w_v_o), 64'h0);
            check("frf_v_empty", 64'(wb.frf_w_v_o), 64'h0);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clk) compare_outputs();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.late_v_i        = 1'b0;
        wb.late_float_i    = 1'b0;
        wb.late_rd_addr_i  = 5'd0;
        wb.late_data_i     = 64'h0;
        wb.alloc_v_i       = 1'b0;
        wb.alloc_float_i   = 1'b0;
        wb.alloc_rd_addr_i = 5'd0;
        wb.irf_w_yumi_i    = 1'b0;
        wb.frf_w_yumi_i    = 1'b0;
    endtask

    task automatic enq(input bit f, input logic [4:0] rd, input logic [63:0] d);
        wb.late_v_i       = 1'b1;
        wb.late_float_i   = f;
        wb.late_rd_addr_i = rd;
        wb.late_data_i    = d;
    endtask

    task automatic alloc(input bit f, input logic [4:0] rd);
        wb.alloc_v_i       = 1'b1;
        wb.alloc_float_i   = f;
        wb.alloc_rd_addr_i = rd;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) step();
        check("rst_empty", 64'(wb.empty_o), 64'h1);
        check("rst_count", 64'(wb.count_o), 64'h0);
        reset_n = 1'b1;
        step();

        // Reset mid-fill
        for (int i = 1; i <= 3; i++) begin
            idle();
            enq(1'b0, 5'(i), 64'h11 * i);
            alloc(1'b0, 5'(i));
            step();
        end
        idle();
        check("t1_count3", 64'(wb.count_o), 64'h3);
        check("t1_pend", 64'(wb.irf_pending_o), 64'h0E);
        reset_n = 1'b0;
        #1;
        check("t1_rst_count", 64'(wb.count_o), 64'h0);
        check("t1_rst_irf_v", 64'(wb.irf_w_v_o), 64'h0);
        check("t1_rst_pend", 64'(wb.irf_pending_o), 64'h0);
        check("t1_rst_empty", 64'(wb.empty_o), 64'h1);
        step();
        reset_n = 1'b1;
        enq(1'b0, 5'd9, 64'h99);
        step();
        idle();
        check("t1_head_addr", 64'(wb.rf_w_addr_o), 64'h9);
        check("t1_head_data", wb.rf_w_data_o, 64'h99);
        check("t1_head_v", 64'(wb.irf_w_v_o), 64'h1);
        wb.irf_w_yumi_i = 1'b1;
        step();
        idle();
        check("t1_drained", 64'(wb.count_o), 64'h0);

        // Full queue, no look-through
        for (int i = 1; i <= 4; i++) begin
            idle();
            enq(1'b0, 5'(i), 64'h100 + i);
            step();
        end
        idle();
        check("t2_full_count", 64'(wb.count_o), 64'h4);
        enq(1'b0, 5'd5, 64'h105);
        #1;
        check("t2_full_nack", 64'(wb.late_yumi_o), 64'h0);
        wb.irf_w_yumi_i = 1'b1;
        #1;
        check("t2_full_yumi_nack", 64'(wb.late_yumi_o), 64'h0);
        step();
        wb.irf_w_yumi_i = 1'b0;
        check("t2_count3", 64'(wb.count_o), 64'h3);
        check("t2_head2", 64'(wb.rf_w_addr_o), 64'h2);
        #1;
        check("t2_accept", 64'(wb.late_yumi_o), 64'h1);
        step();
        idle();
        check("t2_count4", 64'(wb.count_o), 64'h4);
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_addr", 64'(wb.rf_w_addr_o), 64'(k + 2));
            wb.irf_w_yumi_i = 1'b1;
            step();
        end
        idle();
        check("t2_empty", 64'(wb.empty_o), 64'h1);

        // Mixed files in strict order
        enq(1'b0, 5'd5, 64'hAA);
        step();
        idle();
        enq(1'b1, 5'd3, 64'hBB);
        alloc(1'b1, 5'd3);
        step();
        idle();
        check("t3_irf_v", 64'(wb.irf_w_v_o), 64'h1);
        check("t3_addr5", 64'(wb.rf_w_addr_o), 64'h5);
        check("t3_dataAA", wb.rf_w_data_o, 64'hAA);
        check("t3_frf_v0", 64'(wb.frf_w_v_o), 64'h0);
        check("t3_fpend3", 64'(wb.frf_pending_o), 64'h8);
        step();
        check("t3_fp_blocked", 64'(wb.frf_w_v_o), 64'h0);
        wb.irf_w_yumi_i = 1'b1;
        step();
        idle();
        check("t3_frf_v1", 64'(wb.frf_w_v_o), 64'h1);
        check("t3_irf_v0", 64'(wb.irf_w_v_o), 64'h0);
        check("t3_addr3", 64'(wb.rf_w_addr_o), 64'h3);
        check("t3_dataBB", wb.rf_w_data_o, 64'hBB);
        wb.frf_w_yumi_i = 1'b1;
        step();
        idle();
        check("t3_fpend_clr", 64'(wb.frf_pending_o), 64'h0);
        check("t3_empty", 64'(wb.empty_o), 64'h1);

        // x0 writes are acknowledged and dropped
        enq(1'b0, 5'd0, 64'h1234);
        alloc(1'b0, 5'd0);
        #1;
        check("t4_yumi", 64'(wb.late_yumi_o), 64'h1);
        step();
        idle();
        check("t4_count0", 64'(wb.count_o), 64'h0);
        check("t4_irf_v0", 64'(wb.irf_w_v_o), 64'h0);
        check("t4_pend0", 64'(wb.irf_pending_o[0]), 64'h0);

        // Scoreboard set-wins collision
        alloc(1'b0, 5'd7);
        step();
        idle();
        check("t5_pend7_set", 64'(wb.irf_pending_o[7]), 64'h1);
        enq(1'b0, 5'd7, 64'h77);
        step();
        enq(1'b0, 5'd7, 64'h78);
        step();
        idle();
        check("t5_count2", 64'(wb.count_o), 64'h2);
        wb.irf_w_yumi_i = 1'b1;
        alloc(1'b0, 5'd7);
        step();
        idle();
        check("t5_pend7_kept", 64'(wb.irf_pending_o[7]), 64'h1);
        check("t5_count1", 64'(wb.count_o), 64'h1);
        check("t5_data78", wb.rf_w_data_o, 64'h78);
        wb.irf_w_yumi_i = 1'b1;
        step();
        idle();
        check("t5_pend7_clr", 64'(wb.irf_pending_o[7]), 64'h0);
        check("t5_count0", 64'(wb.count_o), 64'h0);

        // Streaming through pointer wrap, alternating files
        for (int k = 0; k <= 10; k++) begin
            idle();
            if (k < 10) enq(k[0], 5'(k + 1), 64'hD000 + 64'(k));
            if (k >= 1) begin
                if (((k - 1) % 2) == 1) wb.frf_w_yumi_i = 1'b1;
                else                    wb.irf_w_yumi_i = 1'b1;
            end
            step();
            if (k < 10) begin
                check("t6_count", 64'(wb.count_o), 64'h1);
                check("t6_data", wb.rf_w_data_o, 64'hD000 + 64'(k));
            end
        end
        idle();
        check("t6_empty", 64'(wb.empty_o), 64'h1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
